// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared types and helpers for the LED/ADC sequencer.
// The DARK phase encoding is used only when AMBIENT_SUB_EN is defined.
package led_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_START,
        ST_WAIT_DONE,
        ST_HOLD
    } seq_state_e;

    typedef enum logic [1:0] {
        PH_RED,
        PH_IR,
        PH_DARK
    } phase_e;

    // Bits needed to count 0..value-1 (at least 1).
    function automatic int clog2(input int unsigned value);
        int width;
        width = 1;
        for (int i = 1; i < 32; i++) begin
            if ((64'(1) << i) < 64'(value)) begin
                width = i + 1;
            end
        end
        return width;
    endfunction

    // LED phase order: RED -> IR (-> DARK) -> RED.
    function automatic phase_e next_phase(input phase_e ph);
`ifdef AMBIENT_SUB_EN
        case (ph)
            PH_RED:  return PH_IR;
            PH_IR:   return PH_DARK;
            default: return PH_RED;
        endcase
`else
        return (ph == PH_RED) ? PH_IR : PH_RED;
`endif
    endfunction

endpackage

// File: rtl/led_adc_sequencer_phase_timer.sv
// phase_timer: per-phase tick counter for the LED/ADC sequencer.
// Counts 0..PHASE_TICKS-1 while run is high and clears synchronously when run is low.
// tc flags the last tick of a phase; settle_hit flags the tick before the conversion
// request, so the request state lines up with count == SETTLE_TICKS.
// SETTLE_TICKS must be at least 1 and below PHASE_TICKS-2.
module phase_timer #(
    parameter int PHASE_TICKS  = 5000,
    parameter int SETTLE_TICKS = 1000,
    parameter int CNT_W        = 13
) (
    input  logic CLK,
    input  logic rst_n,
    input  logic run,
    output logic tc,
    output logic settle_hit
);

    localparam logic [CNT_W-1:0] LAST_CNT      = CNT_W'(PHASE_TICKS - 1);
    localparam logic [CNT_W-1:0] PRE_START_CNT = CNT_W'(SETTLE_TICKS - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign tc         = run && (count_q == LAST_CNT);
    assign settle_hit = run && (count_q == PRE_START_CNT);

    // Next count: wrap at terminal count, hold at zero while stopped.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        count_d = count_q;
        if (!run || tc) begin
            count_d = '0;
        end else begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge CLK or negedge rst_n) begin
        // NOTE: state is written with <= so every flop samples pre-edge values.
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/led_adc_sequencer.sv
// led_adc_sequencer: alternates red/IR LED drive, requests one ADC conversion per
// LED phase after a settle delay, and hands each result to the matching FIR with a
// one-cycle valid strobe. Missed conversions raise a sticky timeout_err.
// Build macro AMBIENT_SUB_EN adds a DARK phase (both LEDs off) whose sample is
// subtracted, clamped at zero, from later red/IR samples.
module led_adc_sequencer
    import led_seq_pkg::*;
#(
    parameter int PHASE_TICKS  = 5000,
    parameter int SETTLE_TICKS = 1000,
    parameter int DATA_W       = 8
) (
    input  logic              CLK,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              adc_done,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              clr_err,
    output logic              adc_start,
    output logic              led_red,
    output logic              led_ir,
    output logic [DATA_W-1:0] red_value,
    output logic              red_valid,
    output logic [DATA_W-1:0] ir_value,
    output logic              ir_valid,
    output logic              timeout_err
);

    localparam int CNT_W = clog2(PHASE_TICKS);

    seq_state_e        state_q, state_d;
    phase_e            phase_q, phase_d;
    logic              led_red_q, led_red_d;
    logic              led_ir_q, led_ir_d;
    logic [DATA_W-1:0] red_value_q, red_value_d;
    logic [DATA_W-1:0] ir_value_q, ir_value_d;
    logic              red_valid_q, red_valid_d;
    logic              ir_valid_q, ir_valid_d;
    logic              timeout_err_q, timeout_err_d;

    logic              tc;
    logic              settle_hit;
    logic              accept;
    logic              timeout_set;
    logic [DATA_W-1:0] sample;

    phase_timer #(
        .PHASE_TICKS (PHASE_TICKS),
        .SETTLE_TICKS(SETTLE_TICKS),
        .CNT_W       (CNT_W)
    ) u_timer (
        .CLK       (CLK),
        .rst_n     (rst_n),
        .run       (enable),
        .tc        (tc),
        .settle_hit(settle_hit)
    );

    // A result counts only while waiting for it; done beats a simultaneous phase end.
    assign accept      = enable && (state_q == ST_WAIT_DONE) && adc_done;
    assign timeout_set = enable && (state_q == ST_WAIT_DONE) && tc && !adc_done;

`ifdef AMBIENT_SUB_EN
    logic [DATA_W-1:0] dark_q, dark_d;
    logic [DATA_W:0]   diff;

    assign diff   = {1'b0, adc_data} - {1'b0, dark_q};
    assign sample = diff[DATA_W] ? '0 : diff[DATA_W-1:0];
`else
    assign sample = adc_data;
`endif

    // Sequencer FSM next state.
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:      state_d = settle_hit ? ST_START : ST_SETTLE;
                ST_SETTLE:    if (settle_hit) state_d = ST_START;
                ST_START:     state_d = ST_WAIT_DONE;
                ST_WAIT_DONE: begin
                    if (tc) begin
                        state_d = ST_SETTLE;
                    end else if (adc_done) begin
                        state_d = ST_HOLD;
                    end
                end
                ST_HOLD:      if (tc) state_d = ST_SETTLE;
                default:      state_d = ST_IDLE;
            endcase
        end
    end

    // Phase, LED drive, sample capture and error flag.
    always_comb begin
        phase_d       = phase_q;
        red_value_d   = red_value_q;
        ir_value_d    = ir_value_q;
        red_valid_d   = 1'b0;
        ir_valid_d    = 1'b0;
        timeout_err_d = timeout_err_q;
`ifdef AMBIENT_SUB_EN
        dark_d        = dark_q;
`endif

        if (!enable) begin
            phase_d = PH_RED;
        end else if (tc) begin
            phase_d = next_phase(phase_q);
        end

        led_red_d = enable && (phase_d == PH_RED);
        led_ir_d  = enable && (phase_d == PH_IR);

        if (accept) begin
            case (phase_q)
                PH_RED: begin
                    red_value_d = sample;
                    red_valid_d = 1'b1;
                end
                PH_IR: begin
                    ir_value_d = sample;
                    ir_valid_d = 1'b1;
                end
                default: begin
`ifdef AMBIENT_SUB_EN
                    dark_d = adc_data;
`endif
                end
            endcase
        end

        if (clr_err) begin
            timeout_err_d = 1'b0;
        end
        if (timeout_set) begin
            timeout_err_d = 1'b1;
        end
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            phase_q       <= PH_RED;
            led_red_q     <= 1'b0;
            led_ir_q      <= 1'b0;
            red_value_q   <= '0;
            ir_value_q    <= '0;
            red_valid_q   <= 1'b0;
            ir_valid_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            led_red_q     <= led_red_d;
            led_ir_q      <= led_ir_d;
            red_value_q   <= red_value_d;
            ir_value_q    <= ir_value_d;
            red_valid_q   <= red_valid_d;
            ir_valid_q    <= ir_valid_d;
            timeout_err_q <= timeout_err_d;
        end
    end

`ifdef AMBIENT_SUB_EN
    // Latest dark (ambient) sample.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            dark_q <= '0;
        end else begin
            dark_q <= dark_d;
        end
    end
`endif

    assign adc_start   = (state_q == ST_START);
    assign led_red     = led_red_q;
    assign led_ir      = led_ir_q;
    assign red_value   = red_value_q;
    assign red_valid   = red_valid_q;
    assign ir_value    = ir_value_q;
    assign ir_valid    = ir_valid_q;
    assign timeout_err = timeout_err_q;

endmodule
